// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared constants and types for the instruction-fetch slice.
//   INST_BYTES    : size of one instruction word in bytes (PC increment)
//   NOP_INST      : word presented to decode when nothing is buffered
//   fetch_entry_t : one buffered fetch, the word together with its PC
package ifetch_pkg;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t with a flush input.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   flush      : discard every entry (wins over push/pop)
//   push, wdata: write wdata at the tail; accepted when not full or when popping
//   pop        : advance the head (ignored when empty)
//   head       : entry at the head (registered storage)
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM,
// buffers words in fetch_fifo and hands them to decode over valid/ready.
// Redirects flush the buffer and restart fetch at the new target.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   fetch_en             : allow new ROM reads (buffer keeps draining when low)
//   rom_addr / rom_data  : ROM byte address (= fetch PC) and same-cycle word
//   inst_valid/ready     : head handshake to decode
//   inst_data / inst_pc  : head word and its PC (NOP / 0 when empty)
//   redirect_valid/pc    : one-cycle branch/jump request
//   fifo_count           : buffer occupancy
// Optional build macro IFETCH_BYPASS_EN: when the buffer is empty, the ROM word
// is presented to decode in the same cycle it is read.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_en,
  output logic [31:0]             rom_addr,
  input  logic [31:0]             rom_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst_data,
  output logic [31:0]             inst_pc,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic [31:0]  fetch_pc;
  fetch_entry_t head;
  fetch_entry_t wdata;
  logic         full;
  logic         empty;
  logic         bypass;
  logic         bypass_take;
  logic         pop;
  logic         push;
  logic         fifo_push;
  logic         fifo_pop;

  assign rom_addr = fetch_pc;
  assign wdata    = '{pc: fetch_pc, inst: rom_data};

`ifdef IFETCH_BYPASS_EN
  // Empty buffer with a live fetch: expose the ROM word directly.
  assign bypass = empty & fetch_en & ~redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid  = ~empty | bypass;
  assign pop         = inst_valid & inst_ready;
  assign bypass_take = bypass & inst_ready;

  // A fetched word that decode takes straight from the ROM still advances the
  // PC, but never enters the buffer.
  assign push      = fetch_en & ~redirect_valid & (~full | pop);
  assign fifo_push = push & ~bypass_take;
  assign fifo_pop  = pop & ~empty;

  always_comb begin
    inst_data = NOP_INST;
    inst_pc   = 32'h0000_0000;
    if (!empty) begin
      inst_data = head.inst;
      inst_pc   = head.pc;
    end else if (bypass) begin
      inst_data = rom_data;
      inst_pc   = fetch_pc;
    end
  end

  // Redirect targets are forced to word alignment; stray low bits are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'(INST_BYTES - 1);
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'(INST_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (fifo_pop),
    .head  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl
// Bench for ifetch_ctrl: directed vector table, then randomized traffic
// checked against a queue-based reference model of the fetch buffer.
// Honors IFETCH_BYPASS_EN when the design is built with it.
module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic           clk;
  logic           reset;
  logic           fetch_en;
  logic [31:0]    rom_addr;
  logic [31:0]    rom_data;
  logic           inst_valid;
  logic           inst_ready;
  logic [31:0]    inst_data;
  logic [31:0]    inst_pc;
  logic           redirect_valid;
  logic [31:0]    redirect_pc;
  logic [CW-1:0]  fifo_count;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return 32'hA000_0000 | {2'b00, a[31:2]};
  endfunction

  assign rom_data = romWord(rom_addr);

  ifetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] edata;
    logic [31:0] eaddr;
    int          ecnt;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mpc;

  function automatic void addVec(input logic rst, fe, rdy, rv, input logic [31:0] rpc,
                                 input logic ev, input logic [31:0] epc, edata, eaddr,
                                 input int ecnt);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.edata = edata; v.eaddr = eaddr; v.ecnt = ecnt;
    vecs.push_back(v);
  endfunction

  task automatic checkField(input string tag, input string name,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s %s cycle %0d: got %h expected %h", tag, name, cycle, act, exp);
  endtask

  task automatic applyStimulus(input logic rst, fe, rdy, rv, input logic [31:0] rpc);
    reset          = rst;
    fetch_en       = fe;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] edata, input logic [31:0] eaddr, input int ecnt);
    checkField(tag, "inst_valid", 32'(inst_valid), 32'(ev));
    checkField(tag, "inst_pc",    inst_pc,   epc);
    checkField(tag, "inst_data",  inst_data, edata);
    checkField(tag, "rom_addr",   rom_addr,  eaddr);
    checkField(tag, "fifo_count", 32'(fifo_count), 32'(ecnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Reference model: compare this cycle's outputs, then advance one clock.
  task automatic modelCycle(input logic rst, fe, rdy, rv, input logic [31:0] rpc);
    logic        byp;
    logic        ev;
    logic        pop;
    int          sz;
    logic [31:0] epc;
    logic [31:0] edata;
    sz  = mq.size();
    byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp = (sz == 0) && fe && !rv;
`endif
    ev = (sz > 0) || byp;
    if (sz > 0) begin
      epc = mq[0].pc; edata = mq[0].inst;
    end else if (byp) begin
      epc = mpc; edata = romWord(mpc);
    end else begin
      epc = 32'h0; edata = NOP;
    end
    applyStimulus(rst, fe, rdy, rv, rpc);
    checkOutput("model", ev, epc, edata, mpc, sz);
    pop = ev && rdy;
    if (rst) begin
      mq.delete();
      mpc = RESET_PC;
    end else if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else if (byp && rdy) begin
      mpc = mpc + 32'd4;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fe && (sz < DEPTH || pop)) begin
        mq.push_back('{pc: mpc, inst: romWord(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();

`ifndef IFETCH_BYPASS_EN
    // Sequential fetch with decode always ready.
    addVec(0,1,1,0,0, 0,32'h0,NOP,32'h0,0);
    addVec(0,1,1,0,0, 1,32'h0,32'hA000_0000,32'h4,1);
    addVec(0,1,1,0,0, 1,32'h4,32'hA000_0001,32'h8,1);
    addVec(0,1,1,0,0, 1,32'h8,32'hA000_0002,32'hC,1);
    addVec(0,1,1,0,0, 1,32'hC,32'hA000_0003,32'h10,1);
    // Reset mid-stream, then backpressure from a clean start.
    addVec(1,1,0,0,0, 1,32'h10,32'hA000_0004,32'h14,1);
    addVec(0,1,0,0,0, 0,32'h0,NOP,32'h0,0);
    addVec(0,1,0,0,0, 1,32'h0,32'hA000_0000,32'h4,1);
    addVec(0,1,0,0,0, 1,32'h0,32'hA000_0000,32'h8,2);
    addVec(0,1,0,0,0, 1,32'h0,32'hA000_0000,32'h8,2);
    addVec(0,1,0,0,0, 1,32'h0,32'hA000_0000,32'h8,2);
    // Release: push and pop together while full.
    addVec(0,1,1,0,0, 1,32'h0,32'hA000_0000,32'h8,2);
    addVec(0,1,1,0,0, 1,32'h4,32'hA000_0001,32'hC,2);
    addVec(0,1,0,0,0, 1,32'h8,32'hA000_0002,32'h10,2);
    // Redirect to an unaligned target while full, popping in the same cycle.
    addVec(0,1,1,1,32'h23, 1,32'h8,32'hA000_0002,32'h10,2);
    addVec(0,1,1,0,0, 0,32'h0,NOP,32'h20,0);
    addVec(0,1,1,0,0, 1,32'h20,32'hA000_0008,32'h24,1);
    // Wrap past the top of the address space.
    addVec(0,1,1,1,32'hFFFF_FFFC, 1,32'h24,32'hA000_0009,32'h28,1);
    addVec(0,1,1,0,0, 0,32'h0,NOP,32'hFFFF_FFFC,0);
    addVec(0,1,0,0,0, 1,32'hFFFF_FFFC,32'hBFFF_FFFF,32'h0,1);
    addVec(0,1,1,0,0, 1,32'hFFFF_FFFC,32'hBFFF_FFFF,32'h4,2);
    addVec(0,1,0,0,0, 1,32'h0,32'hA000_0000,32'h8,2);
    // Pause: buffer drains, then NOP.
    addVec(0,0,1,0,0, 1,32'h0,32'hA000_0000,32'h8,2);
    addVec(0,0,1,0,0, 1,32'h4,32'hA000_0001,32'h8,1);
    addVec(0,0,1,0,0, 0,32'h0,NOP,32'h8,0);
    // Redirect while paused still moves the PC.
    addVec(0,0,1,1,32'h40, 0,32'h0,NOP,32'h8,0);
    addVec(0,0,0,0,0, 0,32'h0,NOP,32'h40,0);
    addVec(0,1,0,0,0, 0,32'h0,NOP,32'h40,0);
    addVec(0,1,0,0,0, 1,32'h40,32'hA000_0010,32'h44,1);
    // Reset with a full buffer.
    addVec(1,1,0,0,0, 1,32'h40,32'hA000_0010,32'h48,2);
    addVec(0,1,1,0,0, 0,32'h0,NOP,32'h0,0);
    addVec(0,1,1,0,0, 1,32'h0,32'hA000_0000,32'h4,1);
`else
    // Zero-latency delivery straight from the ROM, buffer stays empty.
    for (int i = 0; i < 4; i++)
      addVec(0,1,1,0,0, 1,32'(4*i),32'hA000_0000 | 32'(i),32'(4*i),0);
    // Decode stalls: the word is pushed instead.
    addVec(0,1,0,0,0, 1,32'h10,32'hA000_0004,32'h10,0);
    addVec(0,1,0,0,0, 1,32'h10,32'hA000_0004,32'h14,1);
    addVec(0,1,1,0,0, 1,32'h10,32'hA000_0004,32'h18,2);
    addVec(0,1,1,0,0, 1,32'h14,32'hA000_0005,32'h1C,2);
    // Redirect blocks the bypass path for that cycle.
    addVec(0,1,1,1,32'h23, 1,32'h18,32'hA000_0006,32'h20,2);
    addVec(0,1,1,0,0, 1,32'h20,32'hA000_0008,32'h20,0);
    addVec(0,0,1,0,0, 0,32'h0,NOP,32'h24,0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      checkOutput("table", vecs[i].ev, vecs[i].epc, vecs[i].edata, vecs[i].eaddr, vecs[i].ecnt);
      tick();
    end

    // Resynchronise to a known state, then random traffic against the model.
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    mq.delete();
    mpc = RESET_PC;
    for (int i = 0; i < 400; i++) begin
      logic        rst, fe, rdy, rv;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 59) == 0);
      fe  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 255));
      modelCycle(rst, fe, rdy, rv, rpc);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
